status_flag_unit: RTL and testbench

Producer side of the NZCV condition-flag interface: computes Negative/Zero/Carry/oVerflow from the execute-stage operation and holds them in the processor status register. Its registered 4-bit flag bus drives the condition-check logic in the decode stage. It sits in the execute stage, alongside the ALU, and honours pipeline freeze and flush.

---
 rtl/status_flag_unit.sv | 121 ++++++++++++
 tb/tb_status_flag_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/status_flag_unit.sv
// NZCV condition-flag producer for the execute stage. Computes flags from the
// current operation, holds them in the status register, exposes the next
// value for forwarding and pulses a change indicator one cycle after update.
module status_flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             s_bit,
  input  logic [2:0]       op_class,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] logic_result,
  input  logic             shifter_carry,
  input  logic             freeze,
  input  logic             flush,
  input  logic             msr_we,
  input  logic [3:0]       msr_data,
  output logic [3:0]       condition_check,
  output logic [3:0]       flags_next,
  output logic             flags_changed
);

  localparam logic [2:0] OpLogic = 3'd0;
  localparam logic [2:0] OpAdd   = 3'd1;
  localparam logic [2:0] OpAdc   = 3'd2;
  localparam logic [2:0] OpSub   = 3'd3;
  localparam logic [2:0] OpSbc   = 3'd4;
  localparam logic [2:0] OpRsb   = 3'd5;

  logic [3:0]       flags_q, flags_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [3:0]       arith_flags, logic_flags, op_flags;
  logic             upd;

  // Adder operand selection; subtraction forms invert one input.
  // Carry-in for ADC/SBC is the registered C, not the forwarded value.
  always_comb begin
    add_x   = op_a;
    add_y   = op_b;
    add_cin = 1'b0;
    case (op_class)
      OpAdd: begin
        add_cin = 1'b0;
      end
      OpAdc: begin
        add_cin = flags_q[1];
      end
      OpSub: begin
        add_y   = ~op_b;
        add_cin = 1'b1;
      end
      OpSbc: begin
        add_y   = ~op_b;
        add_cin = flags_q[1];
      end
      OpRsb: begin
        add_x   = op_b;
        add_y   = ~op_a;
        add_cin = 1'b1;
      end
      default: begin
        add_x   = op_a;
        add_y   = op_b;
        add_cin = 1'b0;
      end
    endcase
  end

  // WIDTH+1-bit sum: bit WIDTH is the carry, never folded into N or Z.
  always_comb begin
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    arith_flags[3] = sum[WIDTH-1];
    arith_flags[2] = (sum[WIDTH-1:0] == '0);
    arith_flags[1] = sum[WIDTH];
    arith_flags[0] = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
  end

  // Logic ops take C from the shifter and keep the current V.
  always_comb begin
    logic_flags = {logic_result[WIDTH-1], (logic_result == '0), shifter_carry, flags_q[0]};
    op_flags    = (op_class == OpLogic) ? logic_flags : arith_flags;
    upd         = valid & s_bit & ~flush & ~freeze & (op_class <= OpRsb);
  end

  // Write priority: freeze holds, then MSR write, then instruction update.
  always_comb begin
    flags_d = flags_q;
    if (freeze) begin
      flags_d = flags_q;
    end else if (msr_we) begin
      flags_d = msr_data;
    end else if (upd) begin
      flags_d = op_flags;
    end
    changed_d = ~freeze & (flags_d != flags_q);
  end

  // Status register and change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= 4'b0000;
      changed_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      changed_q <= changed_d;
    end
  end

  // Change pulse is suppressed for the whole duration of a freeze.
  always_comb begin
    condition_check = flags_q;
    flags_next      = flags_d;
    flags_changed   = changed_q & ~freeze;
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed vectors with literal expectations plus
// an arithmetic reference model compared on every falling clock edge.
module tb_status_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, s_bit, shifter_carry, freeze, flush, msr_we;
  logic [2:0]  op_class;
  logic [31:0] op_a, op_b, logic_result;
  logic [3:0]  msr_data;
  logic [3:0]  condition_check, flags_next;
  logic        flags_changed;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_flags = 4'b0000;
  logic       m_chg   = 1'b0;

  status_flag_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid          (valid),
    .s_bit          (s_bit),
    .op_class       (op_class),
    .op_a           (op_a),
    .op_b           (op_b),
    .logic_result   (logic_result),
    .shifter_carry  (shifter_carry),
    .freeze         (freeze),
    .flush          (flush),
    .msr_we         (msr_we),
    .msr_data       (msr_data),
    .condition_check(condition_check),
    .flags_next     (flags_next),
    .flags_changed  (flags_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on 64-bit values.
  function automatic logic [3:0] model_next(input logic [3:0] cur);
    longint ua, ub, sa, sb, u, s, cin, lim;
    logic [31:0] r;
    logic c, v;
    if (freeze) return cur;
    if (msr_we) return msr_data;
    if (!valid || !s_bit || flush || op_class > 3'd5) return cur;
    if (op_class == 3'd0)
      return {logic_result[31], logic_result == 32'd0, shifter_carry, cur[0]};
    ua  = longint'({32'd0, op_a});
    ub  = longint'({32'd0, op_b});
    sa  = longint'($signed(op_a));
    sb  = longint'($signed(op_b));
    cin = cur[1] ? 64'sd1 : 64'sd0;
    lim = 64'sd2147483648;
    u = 0;
    s = 0;
    c = 1'b0;
    case (op_class)
      3'd1: begin u = ua + ub;       s = sa + sb;       c = (u >= 64'sd4294967296); end
      3'd2: begin u = ua + ub + cin; s = sa + sb + cin; c = (u >= 64'sd4294967296); end
      3'd3: begin u = ua - ub;             s = sa - sb;             c = (u >= 0); end
      3'd4: begin u = ua - ub - (1 - cin); s = sa - sb - (1 - cin); c = (u >= 0); end
      default: begin u = ub - ua;          s = sb - sa;             c = (u >= 0); end
    endcase
    r = u[31:0];
    v = (s >= lim) || (s < -lim);
    return {r[31], r == 32'd0, c, v};
  endfunction

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flags <= 4'b0000;
      m_chg   <= 1'b0;
    end else begin
      m_chg   <= !freeze && (model_next(m_flags) != m_flags);
      m_flags <= model_next(m_flags);
    end
  end

  // Compare process: every falling edge, inputs are stable.
  always @(negedge clk) begin
    logic [3:0] exp_next;
    exp_next = model_next(m_flags);
    check("model_cc", condition_check, m_flags);
    check("model_next", flags_next, exp_next);
    check("model_chg", {3'b000, flags_changed}, {3'b000, m_chg & ~freeze});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] cls, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    valid    = 1'b1;
    s_bit    = s;
    op_class = cls;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; s_bit = 1'b0; op_class = 3'd0; op_a = '0; op_b = '0;
    logic_result = '0; shifter_carry = 1'b0; freeze = 1'b0; flush = 1'b0;
    msr_we = 1'b0; msr_data = 4'b0000;
    tick();
    tick();
    check("reset_cc", condition_check, 4'b0000);
    check("reset_chg", {3'b000, flags_changed}, 4'b0000);
    rst = 1'b0;
    tick();

    set_op(3'd1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1); tick();
    check("add_ovf", condition_check, 4'b1001);
    check("add_chg_pulse", {3'b000, flags_changed}, 4'b0001);
    valid = 1'b0; tick();
    check("add_chg_clear", {3'b000, flags_changed}, 4'b0000);

    set_op(3'd3, 32'd5, 32'd5, 1'b1); tick();
    check("sub_eq", condition_check, 4'b0110);
    set_op(3'd3, 32'd3, 32'd5, 1'b1); tick();
    check("sub_neg", condition_check, 4'b1000);
    set_op(3'd3, 32'd5, 32'd5, 1'b1); tick();
    set_op(3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1); tick();
    check("adc_carry", condition_check, 4'b0110);
    check("adc_nochg", {3'b000, flags_changed}, 4'b0000);
    set_op(3'd2, 32'hFFFF_FFFF, 32'd0, 1'b0); tick();
    check("no_sbit", condition_check, 4'b0110);
    check("no_sbit_chg", {3'b000, flags_changed}, 4'b0000);
    set_op(3'd4, 32'd5, 32'd5, 1'b1); tick();
    check("sbc_c1", condition_check, 4'b0110);
    set_op(3'd5, 32'd1, 32'd0, 1'b1); tick();
    check("rsb_neg", condition_check, 4'b1000);
    set_op(3'd4, 32'd5, 32'd5, 1'b1); tick();
    check("sbc_c0", condition_check, 4'b1000);
    set_op(3'd3, 32'h8000_0000, 32'd1, 1'b1); tick();
    check("sub_ovf", condition_check, 4'b0011);

    set_op(3'd1, 32'h7FFF_FFFF, 32'd1, 1'b1); tick();
    set_op(3'd0, 32'd0, 32'd0, 1'b1);
    logic_result = 32'd0; shifter_carry = 1'b1; tick();
    check("logic_keep_v", condition_check, 4'b0111);
    set_op(3'd6, 32'd0, 32'd1, 1'b1); tick();
    check("reserved", condition_check, 4'b0111);

    set_op(3'd1, 32'h7FFF_FFFF, 32'd1, 1'b1);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_hold", condition_check, 4'b0111);
      check("freeze_chg", {3'b000, flags_changed}, 4'b0000);
    end
    freeze = 1'b0; tick();
    check("unfreeze_upd", condition_check, 4'b1001);
    check("unfreeze_chg", {3'b000, flags_changed}, 4'b0001);

    set_op(3'd3, 32'd5, 32'd5, 1'b1);
    flush = 1'b1; tick();
    check("flush_block", condition_check, 4'b1001);
    flush = 1'b0;
    set_op(3'd3, 32'd5, 32'd5, 1'b1);
    msr_we = 1'b1; msr_data = 4'b1010; tick();
    check("msr_wins", condition_check, 4'b1010);
    flush = 1'b1; msr_data = 4'b1111; tick();
    check("msr_flush", condition_check, 4'b1111);
    check("msr_chg", {3'b000, flags_changed}, 4'b0001);

    #3 rst = 1'b1;
    #1;
    check("async_rst_cc", condition_check, 4'b0000);
    check("async_rst_chg", {3'b000, flags_changed}, 4'b0000);
    flush = 1'b0; freeze = 1'b1;
    set_op(3'd1, 32'h7FFF_FFFF, 32'd1, 1'b1);
    tick();
    check("rst_beats_all", condition_check, 4'b0000);
    rst = 1'b0; freeze = 1'b0; msr_we = 1'b0;
    tick();
    check("resume_add", condition_check, 4'b1001);
    set_op(3'd3, 32'd3, 32'd5, 1'b1); tick();
    check("resume_sub", condition_check, 4'b1000);
    valid = 1'b0; tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
